// File: rtl/mbc_pkg.sv
// Shared definitions for the MBC3 mapper: address regions, magic values,
// RTC select codes, RTC time record and the RTC read formatting helper.
package mbc_pkg;

  // Address regions keyed on a[15:13]
  localparam logic [2:0] RGN_ENABLE = 3'b000;  // 0000-1FFF
  localparam logic [2:0] RGN_ROMB   = 3'b001;  // 2000-3FFF
  localparam logic [2:0] RGN_SELECT = 3'b010;  // 4000-5FFF
  localparam logic [2:0] RGN_LATCH  = 3'b011;  // 6000-7FFF
  localparam logic [2:0] RGN_EXT    = 3'b101;  // A000-BFFF

  localparam logic [3:0] RAM_ENABLE_MAGIC = 4'hA;

  // RTC register select codes
  localparam logic [3:0] SEL_RTC_S  = 4'h8;
  localparam logic [3:0] SEL_RTC_M  = 4'h9;
  localparam logic [3:0] SEL_RTC_H  = 4'hA;
  localparam logic [3:0] SEL_RTC_DL = 4'hB;
  localparam logic [3:0] SEL_RTC_DH = 4'hC;

  localparam logic [7:0] LATCH_ARM  = 8'h00;
  localparam logic [7:0] LATCH_FIRE = 8'h01;
  localparam logic [7:0] OPEN_BUS   = 8'hFF;

  typedef enum logic [2:0] {
    RTC_S  = 3'd0,
    RTC_M  = 3'd1,
    RTC_H  = 3'd2,
    RTC_DL = 3'd3,
    RTC_DH = 3'd4
  } rtc_field_e;

  typedef struct packed {
    logic [5:0] s;
    logic [5:0] m;
    logic [4:0] h;
    logic [8:0] day;
    logic       halt;
    logic       carry;
  } rtc_time_t;

  function automatic logic rtc_sel_valid(input logic [3:0] sel);
    return (sel >= SEL_RTC_S) && (sel <= SEL_RTC_DH);
  endfunction

  function automatic rtc_field_e rtc_field(input logic [3:0] sel);
    case (sel)
      SEL_RTC_S:  return RTC_S;
      SEL_RTC_M:  return RTC_M;
      SEL_RTC_H:  return RTC_H;
      SEL_RTC_DL: return RTC_DL;
      SEL_RTC_DH: return RTC_DH;
      default:    return RTC_S;
    endcase
  endfunction

  // Host view of one RTC register; unused bits read as 1
  function automatic logic [7:0] rtc_pack(input rtc_field_e f, input rtc_time_t t);
    logic [7:0] v;
    v = 8'hFF;
    case (f)
      RTC_S:   v = {2'b11, t.s};
      RTC_M:   v = {2'b11, t.m};
      RTC_H:   v = {3'b111, t.h};
      RTC_DL:  v = t.day[7:0];
      RTC_DH:  v = {t.carry, t.halt, 5'b11111, t.day[8]};
      default: v = 8'hFF;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rtc_counter.sv
// Live timekeeper: prescaler, S/M/H/day counters, halt and sticky day carry.
// Host writes take priority over a tick landing in the same clock.
module rtc_counter
  import mbc_pkg::*;
#(
  parameter int RTC_DIV = 4194304
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_we,
  input  rtc_field_e i_field,
  input  logic [7:0] i_din,
  output rtc_time_t  o_time
);

  localparam int PW = (RTC_DIV > 1) ? $clog2(RTC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(RTC_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [5:0]    r_s, r_m;
  logic [4:0]    r_h;
  logic [8:0]    r_day;
  logic          r_halt, r_carry;

  logic          w_tick;
  logic [5:0]    w_s_nx, w_m_nx, w_m_step;
  logic [4:0]    w_h_nx, w_h_step;
  logic [8:0]    w_day_nx;
  logic          w_s_cy, w_m_cy, w_h_cy, w_day_cy;

  assign w_tick = !r_halt && (r_presc == PRESC_LAST);

  // Prescaler: frozen by halt, restarted by a seconds write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_presc <= {PW{1'b0}};
    else if (i_we && (i_field == RTC_S))    r_presc <= {PW{1'b0}};
    else if (r_halt)                        r_presc <= r_presc;
    else if (w_tick)                        r_presc <= {PW{1'b0}};
    else                                    r_presc <= r_presc + PW'(1);
  end

  // Carry chain; out-of-range S/M/H run up to field max then wrap silently
  always_comb begin
    w_s_cy   = (r_s == 6'd59);
    w_s_nx   = (w_s_cy || (r_s == 6'd63)) ? 6'd0 : r_s + 6'd1;
    w_m_step = ((r_m == 6'd59) || (r_m == 6'd63)) ? 6'd0 : r_m + 6'd1;
    w_m_cy   = w_s_cy && (r_m == 6'd59);
    w_m_nx   = w_s_cy ? w_m_step : r_m;
    w_h_step = ((r_h == 5'd23) || (r_h == 5'd31)) ? 5'd0 : r_h + 5'd1;
    w_h_cy   = w_m_cy && (r_h == 5'd23);
    w_h_nx   = w_m_cy ? w_h_step : r_h;
    w_day_cy = w_h_cy && (r_day == 9'd511);
    w_day_nx = w_h_cy ? r_day + 9'd1 : r_day;
  end

  // Time registers: host write wins, otherwise advance on tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s     <= 6'd0;
      r_m     <= 6'd0;
      r_h     <= 5'd0;
      r_day   <= 9'd0;
      r_halt  <= 1'b0;
      r_carry <= 1'b0;
    end else if (i_we) begin
      case (i_field)
        RTC_S:  r_s <= i_din[5:0];
        RTC_M:  r_m <= i_din[5:0];
        RTC_H:  r_h <= i_din[4:0];
        RTC_DL: r_day[7:0] <= i_din;
        RTC_DH: begin
          r_day[8] <= i_din[0];
          r_halt   <= i_din[6];
          r_carry  <= i_din[7];
        end
        default: r_s <= r_s;
      endcase
    end else if (w_tick) begin
      r_s     <= w_s_nx;
      r_m     <= w_m_nx;
      r_h     <= w_h_nx;
      r_day   <= w_day_nx;
      r_carry <= r_carry | w_day_cy;
    end
  end

  assign o_time = {r_s, r_m, r_h, r_day, r_halt, r_carry};

endmodule

// File: rtl/mbc3_rtc.sv
// MBC3 cartridge mapper: write decode, ROM/RAM banking, RTC latch and
// combinational host read mux. Timekeeping lives in rtc_counter.
module mbc3_rtc
  import mbc_pkg::*;
#(
  parameter int RTC_DIV     = 4194304,
  parameter int ROM_BANKS_W = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0]             a,
  input  logic [7:0]              din,
  output logic [7:0]              dout,
  input  logic                    wr,
  input  logic                    rd,
  output logic [ROM_BANKS_W+13:0] rom_a,
  input  logic [7:0]              rom_d,
  output logic [14:0]             ram_a,
  input  logic [7:0]              ram_d_in,
  output logic                    ram_we
);

  logic                   r_wr_d, r_en, r_armed, r_ram_we;
  logic [ROM_BANKS_W-1:0] r_rom_bank;
  logic [3:0]             r_sel;
  rtc_time_t              r_latch;

  logic                   w_wr_pulse, w_ram_sel, w_rtc_sel, w_rtc_we;
  logic [2:0]             w_rgn;
  logic [ROM_BANKS_W-1:0] w_bank_eff;
  rtc_field_e             w_field;
  rtc_time_t              w_live;

  assign w_rgn      = a[15:13];
  assign w_wr_pulse = wr & ~r_wr_d;
  assign w_ram_sel  = r_en && (r_sel[3:2] == 2'b00);
  assign w_rtc_sel  = r_en && rtc_sel_valid(r_sel);
  assign w_field    = rtc_field(r_sel);
  assign w_rtc_we   = w_wr_pulse && (w_rgn == RGN_EXT) && w_rtc_sel;
  // Bank 0 cannot be mapped into the switchable window
  assign w_bank_eff = (r_rom_bank == {ROM_BANKS_W{1'b0}}) ? ROM_BANKS_W'(1) : r_rom_bank;
  assign rom_a      = a[14] ? {w_bank_eff, a[13:0]} : {{ROM_BANKS_W{1'b0}}, a[13:0]};
  assign ram_a      = {r_sel[1:0], a[12:0]};
  assign ram_we     = r_ram_we;

  // Host write edge detector: one action per wr assertion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_wr_d <= 1'b0;
    else      r_wr_d <= wr;
  end

  // Mapper control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en       <= 1'b0;
      r_rom_bank <= ROM_BANKS_W'(1);
      r_sel      <= 4'd0;
    end else if (w_wr_pulse) begin
      case (w_rgn)
        RGN_ENABLE: r_en       <= (din[3:0] == RAM_ENABLE_MAGIC);
        RGN_ROMB:   r_rom_bank <= din[ROM_BANKS_W-1:0];
        RGN_SELECT: r_sel      <= din[3:0];
        default:    r_en       <= r_en;
      endcase
    end
  end

  // Latch sequencer: 0x00 arms, an immediately following 0x01 copies live time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_armed <= 1'b0;
      r_latch <= {$bits(rtc_time_t){1'b0}};
    end else if (w_wr_pulse && (w_rgn == RGN_LATCH)) begin
      r_armed <= (din == LATCH_ARM);
      if (r_armed && (din == LATCH_FIRE)) r_latch <= w_live;
    end
  end

  // SRAM write strobe, one clock per host write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ram_we <= 1'b0;
    else      r_ram_we <= w_wr_pulse && (w_rgn == RGN_EXT) && w_ram_sel;
  end

  // Host read mux; idle bus and unmapped space read as open bus
  always_comb begin
    dout = OPEN_BUS;
    if (!rd)                    dout = OPEN_BUS;
    else if (!a[15])            dout = rom_d;
    else if (w_rgn != RGN_EXT)  dout = OPEN_BUS;
    else if (w_ram_sel)         dout = ram_d_in;
    else if (w_rtc_sel)         dout = rtc_pack(w_field, r_latch);
    else                        dout = OPEN_BUS;
  end

  rtc_counter #(.RTC_DIV(RTC_DIV)) u_rtc (
    .clk     (clk),
    .rst_n   (rst),
    .i_we    (w_rtc_we),
    .i_field (w_field),
    .i_din   (din),
    .o_time  (w_live)
  );

endmodule

// File: tb/tb_mbc3_rtc.sv
// Self-checking bench for mbc3_rtc with a fast RTC (RTC_DIV=4).
module tb_mbc3_rtc;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [7:0]  din, dout;
  logic        wr, rd;
  logic [20:0] rom_a;
  logic [7:0]  rom_d;
  logic [14:0] ram_a;
  logic [7:0]  ram_d_in;
  logic        ram_we;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [14:0] exp_ram_q[$];
  logic [14:0] obs_ram_q[$];

  always #5 clk = ~clk;

  mbc3_rtc #(.RTC_DIV(4), .ROM_BANKS_W(7)) dut (
    .clk(clk), .rst(rst), .a(a), .din(din), .dout(dout), .wr(wr), .rd(rd),
    .rom_a(rom_a), .rom_d(rom_d), .ram_a(ram_a), .ram_d_in(ram_d_in), .ram_we(ram_we)
  );

  // Record every SRAM strobe with its address
  always @(negedge clk) begin
    if (ram_we === 1'b1) obs_ram_q.push_back(ram_a);
  end

  task automatic host_write(input logic [15:0] addr, input logic [7:0] data, input int hold);
    @(negedge clk);
    a = addr; din = data; wr = 1'b1;
    repeat (hold) @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; wr = 1'b0; rd = 1'b1; din = 8'h00; a = 16'h4000;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (rom_a !== 21'h04000) begin n_fail++; $display("FAIL reset_rom_a: got %h want %h", rom_a, 21'h04000); end
    n_cmp++; if (dout !== 8'h3C) begin n_fail++; $display("FAIL reset_dout_rom: got %h want %h", dout, 8'h3C); end
    n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    a = 16'hA000; #1;
    n_cmp++; if (dout !== 8'hFF) begin n_fail++; $display("FAIL reset_ext_read: got %h want ff", dout); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_rom_bank();
    host_write(16'h2000, 8'h00, 1);
    a = 16'h4000; #1;
    n_cmp++; if (rom_a !== 21'h04000) begin n_fail++; $display("FAIL rom_bank0_subst: got %h want %h", rom_a, 21'h04000); end
    host_write(16'h2000, 8'h15, 1);
    a = 16'h4000; #1;
    n_cmp++; if (rom_a !== 21'h54000) begin n_fail++; $display("FAIL rom_bank15: got %h want %h", rom_a, 21'h54000); end
    a = 16'h7FFF; #1;
    n_cmp++; if (rom_a !== 21'h57FFF) begin n_fail++; $display("FAIL rom_bank15_top: got %h want %h", rom_a, 21'h57FFF); end
    a = 16'h1234; #1;
    n_cmp++; if (rom_a !== 21'h01234) begin n_fail++; $display("FAIL rom_fixed_bank: got %h want %h", rom_a, 21'h01234); end
  endtask

  task automatic test_ram_write();
    logic [14:0] e, o;
    host_write(16'h0000, 8'h0A, 4);
    host_write(16'h4000, 8'h02, 1);
    exp_ram_q.push_back(15'h4123);
    host_write(16'hA123, 8'h42, 4);
    repeat (2) @(negedge clk);
    n_cmp++; if (obs_ram_q.size() != 1) begin n_fail++; $display("FAIL ram_we_count: got %0d want 1", obs_ram_q.size()); end
    while (exp_ram_q.size() > 0 && obs_ram_q.size() > 0) begin
      e = exp_ram_q.pop_front(); o = obs_ram_q.pop_front();
      n_cmp++; if (o !== e) begin n_fail++; $display("FAIL ram_a: got %h want %h", o, e); end
    end
    exp_ram_q.delete(); obs_ram_q.delete();
    a = 16'hA123; #1;
    n_cmp++; if (dout !== 8'h96) begin n_fail++; $display("FAIL ram_read: got %h want 96", dout); end
    host_write(16'h4000, 8'h05, 1);
    a = 16'hA000; #1;
    n_cmp++; if (dout !== 8'hFF) begin n_fail++; $display("FAIL sel5_read: got %h want ff", dout); end
    host_write(16'h4000, 8'h0D, 1);
    a = 16'hA000; #1;
    n_cmp++; if (dout !== 8'hFF) begin n_fail++; $display("FAIL selD_read: got %h want ff", dout); end
  endtask

  task automatic test_rtc_rollover();
    logic [7:0] exp_v [0:4];
    exp_v[0] = 8'hC0; exp_v[1] = 8'hC0; exp_v[2] = 8'hE0; exp_v[3] = 8'h00; exp_v[4] = 8'hBE;
    host_write(16'h4000, 8'h0C, 1); host_write(16'hA000, 8'h41, 1);  // halt, day8=1
    host_write(16'h4000, 8'h0B, 1); host_write(16'hA000, 8'hFF, 1);
    host_write(16'h4000, 8'h0A, 1); host_write(16'hA000, 8'd23, 1);
    host_write(16'h4000, 8'h09, 1); host_write(16'hA000, 8'd59, 1);
    host_write(16'h4000, 8'h08, 1); host_write(16'hA000, 8'd59, 1);
    host_write(16'h4000, 8'h0C, 1); host_write(16'hA000, 8'h01, 1);  // run
    repeat (4) @(posedge clk);
    host_write(16'h6000, 8'h00, 1); host_write(16'h6000, 8'h01, 1);
    for (int i = 0; i < 5; i++) begin
      host_write(16'h4000, 8'(8 + i), 1);
      a = 16'hA000; #1;
      n_cmp++; if (dout !== exp_v[i]) begin n_fail++; $display("FAIL rollover_reg%0d: got %h want %h", i, dout, exp_v[i]); end
    end
  endtask

  task automatic test_halt_s63();
    host_write(16'h4000, 8'h0C, 1); host_write(16'hA000, 8'h40, 1);
    host_write(16'h4000, 8'h09, 1); host_write(16'hA000, 8'd5, 1);
    host_write(16'h4000, 8'h08, 1); host_write(16'hA000, 8'd63, 1);
    host_write(16'h4000, 8'h0C, 1); host_write(16'hA000, 8'h00, 1);
    repeat (4) @(posedge clk);
    host_write(16'hA000, 8'h40, 1);                                   // halt right after tick
    repeat (20) @(posedge clk);
    host_write(16'h6000, 8'h00, 1); host_write(16'h6000, 8'h01, 1);
    host_write(16'h4000, 8'h08, 1); a = 16'hA000; #1;
    n_cmp++; if (dout !== 8'hC0) begin n_fail++; $display("FAIL s63_wrap: got %h want c0", dout); end
    host_write(16'h4000, 8'h09, 1); a = 16'hA000; #1;
    n_cmp++; if (dout !== 8'hC5) begin n_fail++; $display("FAIL s63_no_carry: got %h want c5", dout); end
    host_write(16'h4000, 8'h0C, 1); a = 16'hA000; #1;
    n_cmp++; if (dout !== 8'h7E) begin n_fail++; $display("FAIL halt_dh: got %h want 7e", dout); end
  endtask

  task automatic test_latch_seq();
    host_write(16'h4000, 8'h08, 1); host_write(16'hA000, 8'd10, 1);
    host_write(16'h6000, 8'h00, 1); host_write(16'h6000, 8'h02, 1); host_write(16'h6000, 8'h01, 1);
    a = 16'hA000; #1;
    n_cmp++; if (dout !== 8'hC0) begin n_fail++; $display("FAIL latch_broken_seq: got %h want c0", dout); end
    host_write(16'h6000, 8'h00, 1); host_write(16'h6000, 8'h01, 1);
    a = 16'hA000; #1;
    n_cmp++; if (dout !== 8'hCA) begin n_fail++; $display("FAIL latch_good_seq: got %h want ca", dout); end
  endtask

  task automatic test_reset_mid();
    host_write(16'h4000, 8'h0C, 1); host_write(16'hA000, 8'h80, 1);  // run, carry=1
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    a = 16'hA000; #1;
    n_cmp++; if (dout !== 8'hFF) begin n_fail++; $display("FAIL midreset_ext: got %h want ff", dout); end
    @(negedge clk); rst = 1'b1;
    a = 16'hA000; #1;
    n_cmp++; if (dout !== 8'hFF) begin n_fail++; $display("FAIL post_reset_disabled: got %h want ff", dout); end
    a = 16'h4000; #1;
    n_cmp++; if (rom_a !== 21'h04000) begin n_fail++; $display("FAIL post_reset_bank: got %h want %h", rom_a, 21'h04000); end
    host_write(16'h0000, 8'h0A, 1);
    a = 16'hA000; #1;
    n_cmp++; if (dout !== 8'h96) begin n_fail++; $display("FAIL post_reset_sel0: got %h want 96", dout); end
    host_write(16'h4000, 8'h08, 1); a = 16'hA000; #1;
    n_cmp++; if (dout !== 8'hC0) begin n_fail++; $display("FAIL latch_reset_s: got %h want c0", dout); end
    host_write(16'h6000, 8'h00, 1); host_write(16'h6000, 8'h01, 1);
    host_write(16'h4000, 8'h0C, 1); a = 16'hA000; #1;
    n_cmp++; if (dout !== 8'h3E) begin n_fail++; $display("FAIL live_reset_dh: got %h want 3e", dout); end
    host_write(16'h0000, 8'h00, 1);
    a = 16'hA000; #1;
    n_cmp++; if (dout !== 8'hFF) begin n_fail++; $display("FAIL disable_read: got %h want ff", dout); end
    n_cmp++; if (obs_ram_q.size() != 0) begin n_fail++; $display("FAIL ram_we_spurious: got %0d strobes want 0", obs_ram_q.size()); end
  endtask

  initial begin
    rom_d = 8'h3C; ram_d_in = 8'h96;
    test_reset();
    test_rom_bank();
    test_ram_write();
    test_rtc_rollover();
    test_halt_s63();
    test_latch_seq();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mbc3_rtc.md
MBC3_RTC -- requirements
Module: mbc3_rtc

Interface
REQ-001 SHALL have parameter RTC_DIV, default 4194304, clk cycles per RTC second.
REQ-002 SHALL have parameter ROM_BANKS_W, default 7, ROM bank register width.
REQ-003 SHALL have port clk  in  1  system clock (4.19 MHz).
REQ-004 SHALL have port rst  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port a  in  16  cartridge address bus from host.
REQ-006 SHALL have port din  in  8  write data from host.
REQ-007 SHALL have port dout  out  8  read data to host.
REQ-008 SHALL have port wr  in  1  host write enable, level, may span several clk.
REQ-009 SHALL have port rd  in  1  host read enable.
REQ-010 SHALL have port rom_a  out  21  physical ROM address {bank, a[13:0]}.
REQ-011 SHALL have port rom_d  in  8  ROM read data.
REQ-012 SHALL have port ram_a  out  15  physical SRAM address {ram_bank[1:0], a[12:0]}.
REQ-013 SHALL have port ram_d_in  in  8  SRAM read data.
REQ-014 SHALL have port ram_we  out  1  SRAM write strobe, one clk.

Function
REQ-015 SHALL act on a write only on the clk after a 0->1 transition of wr; one register update per wr assertion.
REQ-016 SHALL decode writes: 0000-1FFF enable (din[3:0]==A enables RAM/RTC, else disables); 2000-3FFF ROM bank (din[6:0]); 4000-5FFF select (din[3:0]); 6000-7FFF latch.
REQ-017 SHALL map 0000-3FFF to ROM bank 0 and 4000-7FFF to ROM bank rom_bank, with rom_bank==0 substituted by 1.
REQ-018 SHALL map A000-BFFF to SRAM when enabled and select in 0-3; ram_we pulses once on the write edge.
REQ-019 SHALL map A000-BFFF to latched RTC registers when enabled and select in 8-C (S,M,H,DL,DH); writes go to live counters.
REQ-020 SHALL drive dout combinationally from the selected source; disabled, unmapped or select outside 0-3/8-C reads 0xFF.
REQ-021 SHALL copy live RTC into latch registers when a write of 0x01 to 6000-7FFF directly follows a write of 0x00 there; any other value clears the armed state.
REQ-022 SHALL increment seconds once per RTC_DIV clk while DH[6] (halt) is 0; halt freezes the prescaler.
REQ-023 SHALL carry S 59->0 into M, M 59->0 into H, H 23->0 into day; S/M (6 bits) and H (5 bits) holding out-of-range values increment to field maximum then wrap to 0 with no carry.
REQ-024 SHALL keep a 9-bit day counter (DL, DH[0]); 511->0 sets DH[7] (carry), sticky until the host writes it 0.
REQ-025 SHALL reset the prescaler to 0 on a write to S.
REQ-026 SHALL give a host write to any RTC field priority over a tick in the same clk and drop that tick.
REQ-027 SHALL read unused RTC bits as 1 (S/M [7:6], H [7:5], DH [5:1]).

Reset
REQ-028 SHALL on rst low: RAM/RTC disabled, rom_bank=1, select=0, latch unarmed, prescaler=0, wr edge detector cleared, ram_we=0.
REQ-029 SHALL reset live and latched RTC fields to 0, halt=0, carry=0; reset mid-count discards the partial second.
REQ-030 SHALL leave dout combinational, yielding ROM bank 0 data or 0xFF per REQ-020 during reset.

Structure
REQ-031 SHALL place address-range constants, enable magic 0xA and RTC select codes 8-C in shared package mbc_pkg.
REQ-032 SHALL implement the timekeeper (prescaler, S/M/H/day counters, halt, carry) as sub-module rtc_counter; top holds decode, banking, latch and read mux.

Verification
REQ-033 SHALL cover: write 0x00 to 2000, read 4000 -> rom_a=0x04000; write 0x15 -> rom_a=0x54000.
REQ-034 SHALL cover: wr held 4 clk writing 0x0A to 0000, then 0x42 to A123 with select 2 -> exactly one ram_we, ram_a=0x4123.
REQ-035 SHALL cover: RTC_DIV=4, set H=23 M=59 S=59 day=511, run 4 clk -> all zero, DH[7]=1 after latch.
REQ-036 SHALL cover: latch sequence 00,01 vs 00,02,01 -> latch updates only in the first case.
REQ-037 SHALL cover: S written 63 -> next tick S=0, M unchanged; halt=1 for 20 clk -> S unchanged.
REQ-038 SHALL cover: rst low mid-second, then enable disabled, read A000 -> 0xFF.
